// File: rtl/expr_eval_if.sv
// expr_eval_if: character stream into the evaluator and its evaluation status out
//   in       ASCII character offered to the evaluator
//   in_valid in is consumed at the next posedge when 1
//   result   signed value of the expression so far
//   ok       stream so far is a complete well-formed expression
//   err      sticky syntax error
//   ovf      sticky signed overflow
interface expr_eval_if #(parameter int WIDTH = 16);
    logic [7:0]       in;
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic             ok;
    logic             err;
    logic             ovf;
    modport master (output in, in_valid, input result, ok, err, ovf);
    modport slave (input in, in_valid, output result, ok, err, ovf);
endinterface

// File: rtl/expr_eval.sv
// expr_eval: evaluates a single-digit "d op d op d" ASCII stream with '*' over '+'/'-'
//   clk  clock, all state changes on posedge
//   clr  synchronous active-low clear, wins over in_valid
//   bus  slave side of expr_eval_if (in/in_valid in, result/ok/err/ovf out)
module expr_eval #(
    parameter int WIDTH = 16
) (
    input logic        clk,
    input logic        clr,
    expr_eval_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DIG, S_OP, S_ERR} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d, term_q, term_d;
    logic             neg_q, neg_d, mul_q, mul_d, err_q, err_d, ovf_q, ovf_d;
    logic [3:0]       d;
    logic             is_dig, is_add, is_sub, is_mul, step_ovf;
    logic [WIDTH:0]   res_x, nres_x;
    logic [WIDTH+3:0] prod_x;

    // Exact sum/difference of two signed WIDTH values, one guard bit wide.
    function automatic logic [WIDTH:0] addsub(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic n);
        logic [WIDTH:0] ax, bx;
        ax = {a[WIDTH-1], a};
        bx = {b[WIDTH-1], b};
        return n ? ax - bx : ax + bx;
    endfunction

    // ASCII digits are 0x30..0x39, so the low nibble is the digit value.
    assign d      = bus.in[3:0];
    assign is_dig = bus.in >= "0" && bus.in <= "9";
    assign is_add = bus.in == "+";
    assign is_sub = bus.in == "-";
    assign is_mul = bus.in == "*";

    assign res_x  = addsub(sum_q, term_q, neg_q);
    assign prod_x = {{4{term_q[WIDTH-1]}}, term_q} * {{WIDTH{1'b0}}, d};

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        term_d   = term_q;
        neg_d    = neg_q;
        mul_d    = mul_q;
        step_ovf = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                S_IDLE: begin
                    state_d = is_dig ? S_DIG : S_ERR;
                    if (is_dig) begin
                        sum_d  = '0;
                        term_d = WIDTH'(d);
                        neg_d  = 1'b0;
                    end
                end
                S_DIG: begin
                    state_d = (is_add || is_sub || is_mul) ? S_OP : S_ERR;
                    if (is_add || is_sub) begin
                        // Fold the finished term into the running sum.
                        sum_d    = res_x[WIDTH-1:0];
                        step_ovf = res_x != {res_x[WIDTH-1], res_x[WIDTH-1:0]};
                        term_d   = '0;
                        neg_d    = is_sub;
                        mul_d    = 1'b0;
                    end
                    if (is_mul) mul_d = 1'b1;
                end
                S_OP: begin
                    state_d = is_dig ? S_DIG : S_ERR;
                    if (is_dig) begin
                        term_d   = mul_q ? prod_x[WIDTH-1:0] : WIDTH'(d);
                        step_ovf = mul_q && prod_x != {{4{prod_x[WIDTH-1]}}, prod_x[WIDTH-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    // The visible result after this edge must also fit, so check it ahead of time.
    assign nres_x = addsub(sum_d, term_d, neg_d);
    assign err_d  = err_q || state_d == S_ERR;
    assign ovf_d  = ovf_q || (bus.in_valid && (step_ovf || nres_x != {nres_x[WIDTH-1], nres_x[WIDTH-1:0]}));

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            term_q  <= '0;
            neg_q   <= 1'b0;
            mul_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            term_q  <= term_d;
            neg_q   <= neg_d;
            mul_q   <= mul_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.result = res_x[WIDTH-1:0];
    assign bus.ok     = state_q == S_DIG;
    assign bus.err    = err_q;
    assign bus.ovf    = ovf_q;
endmodule
